riscv_fetch_stage: RTL and testbench

- IF stage of the 5-stage RISC-V pipeline.
- Owns the PC and issues word reads to the 256-entry instruction ROM, which the testbench driver loads.
- Buffers returned instructions in a 2-entry skid queue and presents {pc, instr} to the IF/ID boundary with a valid/ready handshake.
- Handles stall (ready low) and branch/jump redirect from EX.

---
 rtl/riscv_pkg.sv | 30 +++
 rtl/riscv_fetch_skidbuf.sv | 67 ++++++
 rtl/riscv_fetch_stage.sv | 150 +++++++++++++++
 tb/tb_riscv_fetch_stage.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_pkg
// Brief    : Shared constants and types for the RISC-V fetch stage.
// Revision : 1.0
// ============================================================================
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam int          ROM_DEPTH = 256;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    // Queue pointers and occupancy are sized for the largest legal depth (4).
    localparam int c_MAX_DEPTH = 4;
    localparam int c_PTR_W     = 2;
    localparam int c_CNT_W     = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_pkt_t;

endpackage
`default_nettype wire

// File: rtl/riscv_fetch_skidbuf.sv
`default_nettype none
// ============================================================================
// Module   : riscv_fetch_skidbuf
// Brief    : BUF_DEPTH-entry circular queue of fetch packets (push/pop/flush).
// Revision : 1.0
// ============================================================================
module riscv_fetch_skidbuf
    import riscv_pkg::*;
#(
    parameter int BUF_DEPTH = 2
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  fetch_pkt_t         push_pkt,
    output fetch_pkt_t         head_pkt,
    output logic [c_CNT_W-1:0] count
);

    fetch_pkt_t           r_mem [c_MAX_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(BUF_DEPTH - 1)) ? '0 : p + c_PTR_W'(1);
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < c_MAX_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_mem[r_wr_ptr] <= push_pkt;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_pkt = r_mem[r_rd_ptr];
    assign count    = r_count;

    // The issue throttle upstream guarantees a slot for every returning word.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && !pop && !flush && (r_count == c_CNT_W'(BUF_DEPTH))));

endmodule
`default_nettype wire

// File: rtl/riscv_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : riscv_fetch_stage
// Brief    : RISC-V IF stage: PC, ROM issue, skid queue, IF/ID valid/ready.
//            Optional perf counters when RISCV_FETCH_PERF_EN is defined.
// Revision : 1.0
// ============================================================================
module riscv_fetch_stage
    import riscv_pkg::*;
#(
    parameter int          ROM_DEPTH = riscv_pkg::ROM_DEPTH,
    parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC,
    parameter int          BUF_DEPTH = 2
)(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fetch_en,
    output logic                         imem_en,
    output logic [$clog2(ROM_DEPTH)-1:0] imem_addr,
    input  logic [XLEN-1:0]              imem_rdata,
    input  logic                         redirect_valid,
    input  logic [XLEN-1:0]              redirect_pc,
    output logic                         id_valid,
    input  logic                         id_ready,
    output logic [XLEN-1:0]              id_pc,
    output logic [XLEN-1:0]              id_instr
`ifdef RISCV_FETCH_PERF_EN
    ,
    output logic [31:0]                  perf_fetched,
    output logic [31:0]                  perf_bubbles
`endif
);

    localparam int c_AW = $clog2(ROM_DEPTH);

    fetch_state_e       r_state;
    fetch_state_e       w_state_nxt;
    logic [XLEN-1:0]    r_pc;
    logic [XLEN-1:0]    r_inflight_pc;
    logic               r_inflight;
    logic [c_AW-1:0]    w_word_nxt;
    logic [XLEN-1:0]    w_pc_inc;
    logic [c_CNT_W-1:0] w_count;
    logic [3:0]         w_occ;
    logic               w_pop;
    logic               w_push;
    logic               w_fetching;
    fetch_pkt_t         w_head;
    fetch_pkt_t         w_push_pkt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The flush state still issues when fetch_en is high, so the redirect
    // target is fetched the cycle after the redirect (3-cycle penalty).
    always_comb begin
        w_state_nxt = r_state;
        w_fetching  = 1'b0;
        imem_en     = 1'b0;
        id_valid    = 1'b0;
        case (r_state)
            S_IDLE:  w_state_nxt = fetch_en ? S_RUN : S_IDLE;
            S_RUN: begin
                w_fetching  = 1'b1;
                w_state_nxt = fetch_en ? S_RUN : S_IDLE;
            end
            S_FLUSH: begin
                w_fetching  = fetch_en;
                w_state_nxt = fetch_en ? S_RUN : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (redirect_valid) begin
            w_state_nxt = S_FLUSH;
        end
        id_valid = (w_count != '0) && !redirect_valid;
        imem_en  = w_fetching && !redirect_valid && (w_occ < 4'(BUF_DEPTH));
    end

    assign w_pop = id_valid && id_ready;
    // Slots already claimed next cycle: queued + returning - leaving.
    assign w_occ = 4'(w_count) + 4'(r_inflight) - 4'(w_pop);

    assign w_word_nxt = r_pc[c_AW+1:2] + c_AW'(1);
    assign w_pc_inc   = {r_pc[XLEN-1:c_AW+2], w_word_nxt, 2'b00};
    assign imem_addr  = r_pc[c_AW+1:2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= imem_en;
            if (imem_en) begin
                r_inflight_pc <= r_pc;
            end
            if (redirect_valid) begin
                r_pc <= redirect_pc & ~32'd3;
            end else if (imem_en) begin
                r_pc <= w_pc_inc;
            end
        end
    end

    assign w_push           = r_inflight && !redirect_valid;
    assign w_push_pkt.pc    = r_inflight_pc;
    assign w_push_pkt.instr = imem_rdata;

    riscv_fetch_skidbuf #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_skidbuf (
        .clk      (clk),
        .rst      (rst),
        .push     (w_push),
        .pop      (w_pop),
        .flush    (redirect_valid),
        .push_pkt (w_push_pkt),
        .head_pkt (w_head),
        .count    (w_count)
    );

    assign id_pc    = w_head.pc;
    assign id_instr = w_head.instr;

`ifdef RISCV_FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (w_pop && (perf_fetched != '1)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if ((r_state == S_RUN) && !id_valid && (perf_bubbles != '1)) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end
`else
    // Default build carries no performance counters.
`endif

endmodule
`default_nettype wire

// File: tb/tb_riscv_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_fetch_stage
// Brief    : Directed self-checking bench for riscv_fetch_stage.
// Revision : 1.0
// ============================================================================
module tb_riscv_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        imem_en;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;

    logic [31:0] rom [256];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    riscv_fetch_stage dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= rom[imem_addr];
    end

    function automatic logic [31:0] rom_word(input int i);
        return 32'h0000_0013 + (32'(i) << 20);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_id(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        chk({tag, "_valid"}, {31'd0, id_valid}, 32'd1);
        chk({tag, "_pc"}, id_pc, pc);
        chk({tag, "_instr"}, id_instr, instr);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = rom_word(i);
        rst = 1'b0; fetch_en = 1'b0; id_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;

        @(negedge clk); #1;
        chk("rst_imem_en",  {31'd0, imem_en},  32'd0);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_pc",    id_pc,    32'd0);
        chk("rst_id_instr", id_instr, 32'd0);

        // cycle 0: release reset
        @(negedge clk); rst = 1'b1; fetch_en = 1'b1; id_ready = 1'b1; #1;
        chk("c0_imem_en", {31'd0, imem_en}, 32'd0);
        @(negedge clk); #1;   // cycle 1
        chk("c1_imem_en", {31'd0, imem_en}, 32'd1);
        chk("c1_addr",    {24'd0, imem_addr}, 32'd0);
        chk("c1_valid",   {31'd0, id_valid}, 32'd0);
        @(negedge clk); #1;   // cycle 2
        chk("c2_addr",  {24'd0, imem_addr}, 32'd1);
        chk("c2_valid", {31'd0, id_valid}, 32'd0);
        for (int k = 3; k <= 4; k++) begin
            @(negedge clk); #1;
            chk_id("seq", 32'((k - 3) * 4), rom_word(k - 3));
        end

        // cycle 5: pc 0x8 presented, stall for 5 cycles
        @(negedge clk); id_ready = 1'b0; #1;
        chk_id("stall_head", 32'h8, rom_word(2));
        chk("stall_c5_imem_en", {31'd0, imem_en}, 32'd0);
        for (int k = 6; k <= 9; k++) begin
            @(negedge clk); #1;
            chk_id("stall_hold", 32'h8, rom_word(2));
            chk("stall_imem_en", {31'd0, imem_en}, 32'd0);
        end
        @(negedge clk); id_ready = 1'b1; #1;   // cycle 10
        chk_id("rel_c10", 32'h8, rom_word(2));
        chk("rel_issue", {31'd0, imem_en}, 32'd1);
        chk("rel_addr",  {24'd0, imem_addr}, 32'd4);
        @(negedge clk); #1;   // cycle 11
        chk_id("rel_c11", 32'hC, rom_word(3));

        // cycle 12: redirect to 0x40 while 0x10 is presented
        @(negedge clk); #1;
        chk_id("pre_redir", 32'h10, rom_word(4));
        redirect_valid = 1'b1; redirect_pc = 32'h40; #1;
        chk("redir_valid",   {31'd0, id_valid}, 32'd0);
        chk("redir_imem_en", {31'd0, imem_en},  32'd0);
        @(negedge clk); redirect_valid = 1'b0; #1;   // R+1
        chk("redir_r1_valid", {31'd0, id_valid}, 32'd0);
        chk("redir_r1_issue", {31'd0, imem_en},  32'd1);
        chk("redir_r1_addr",  {24'd0, imem_addr}, 32'd16);
        @(negedge clk); #1;   // R+2
        chk("redir_r2_valid", {31'd0, id_valid}, 32'd0);
        @(negedge clk); #1;   // R+3
        chk_id("redir_r3", 32'h40, rom_word(16));
        @(negedge clk); #1;   // cycle 16
        chk_id("redir_r4", 32'h44, rom_word(17));

        // misaligned redirect and ROM wrap
        redirect_valid = 1'b1; redirect_pc = 32'h3FE; #1;
        chk("wrap_redir_valid", {31'd0, id_valid}, 32'd0);
        @(negedge clk); redirect_valid = 1'b0; #1;   // cycle 17
        chk("wrap_issue", {31'd0, imem_en}, 32'd1);
        chk("wrap_addr",  {24'd0, imem_addr}, 32'd255);
        @(negedge clk); #1;   // cycle 18
        chk("wrap_addr_next", {24'd0, imem_addr}, 32'd0);
        @(negedge clk); #1;   // cycle 19
        chk_id("wrap_last", 32'h3FC, rom_word(255));

        // fetch_en low for 4 cycles (20..23)
        @(negedge clk); fetch_en = 1'b0; #1;   // cycle 20
        chk_id("wrap_zero", 32'h0, rom_word(0));
        chk("fe_c20_imem_en", {31'd0, imem_en}, 32'd1);
        @(negedge clk); #1;   // cycle 21
        chk_id("fe_drain0", 32'h4, rom_word(1));
        chk("fe_c21_imem_en", {31'd0, imem_en}, 32'd0);
        @(negedge clk); #1;   // cycle 22
        chk_id("fe_drain1", 32'h8, rom_word(2));
        chk("fe_c22_imem_en", {31'd0, imem_en}, 32'd0);
        @(negedge clk); #1;   // cycle 23
        chk("fe_empty_valid", {31'd0, id_valid}, 32'd0);
        chk("fe_c23_imem_en", {31'd0, imem_en},  32'd0);
        @(negedge clk); fetch_en = 1'b1; #1;   // cycle 24
        chk("fe_c24_imem_en", {31'd0, imem_en}, 32'd0);
        @(negedge clk); #1;   // cycle 25
        chk("fe_resume_issue", {31'd0, imem_en}, 32'd1);
        chk("fe_resume_addr",  {24'd0, imem_addr}, 32'd3);
        @(negedge clk); #1;   // cycle 26
        @(negedge clk); id_ready = 1'b0; #1;   // cycle 27
        chk_id("fe_resume", 32'hC, rom_word(3));
        @(negedge clk); #1;   // cycle 28: queue full
        chk_id("full_hold", 32'hC, rom_word(3));
        chk("full_imem_en", {31'd0, imem_en}, 32'd0);

        // mid-stream reset
        @(negedge clk); rst = 1'b0; #1;
        chk("mrst_valid",   {31'd0, id_valid}, 32'd0);
        chk("mrst_imem_en", {31'd0, imem_en},  32'd0);
        chk("mrst_id_pc",   id_pc, 32'd0);
        @(negedge clk); rst = 1'b1; id_ready = 1'b1; #1;
        chk("mrst_c0_imem_en", {31'd0, imem_en}, 32'd0);
        @(negedge clk); #1;
        chk("mrst_c1_issue", {31'd0, imem_en}, 32'd1);
        chk("mrst_c1_addr",  {24'd0, imem_addr}, 32'd0);
        @(negedge clk); #1;
        chk("mrst_c2_valid", {31'd0, id_valid}, 32'd0);
        @(negedge clk); #1;
        chk_id("mrst_first", 32'h0, rom_word(0));
        @(negedge clk); #1;
        chk_id("mrst_second", 32'h4, rom_word(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
